bamse_gpio: RTL and testbench
=============================

# bamse_gpio

Parametrised, PicoBlaze port-mapped GPIO peripheral that generalises the fixed push-button, switch and LED ports of the bamse SoC. It provides:
- `IN_WIDTH` synchronised and optionally debounced inputs;
- `OUT_WIDTH` registered outputs;
- per-bit edge capture with selectable polarity;
- a maskable level interrupt.

It sits inside bamse on the processor's `port_id` / strobe bus at a configurable base address.

## Interface
- `IN_WIDTH`, 8: number of input pins, 1..8.
- `OUT_WIDTH`, 8: number of output pins, 1..8.
- `BASE_ADDR`, 8'h00: port_id of register 0. Must be a multiple of 8.
- `DEBOUNCE_CYCLES`, 16: consecutive stable clocks needed to accept an input change, ≥1. Used only with `GPIO_DEBOUNCE_EN`.

Ports:
- `clk`  in  1  system clock (32 MHz on Papilio Duo).
- `rst`  in  1  reset; synchronous, active-high.
- `port_id`  in  8  PicoBlaze port address.
- `write_strobe`  in  1  one-cycle write qualifier.
- `read_strobe`  in  1  one-cycle read qualifier.
- `out_port`  in  8  write data from the CPU.
- `in_port`  out  8  read data to the CPU; registered.
- `pins_in`  in  IN_WIDTH  asynchronous external inputs.
- `pins_out`  out  OUT_WIDTH  output register contents.
- `irq`  out  1  level interrupt to the CPU; registered.

## Operation
Register map, as offsets from `BASE_ADDR`. Unused upper bits read as 0; writes to them are ignored.
- 0 IN (RO): stable input value, zero-extended.
- 1 OUT (RW): drives `pins_out`.
- 2 EDGE (R, W1C): captured edge flags.
- 3 MASK (RW): interrupt enable per input bit.
- 4 POL (RW): edge polarity per bit; 0 = rising, 1 = falling.
- 5..7: read as 0x00; writes are ignored.

Behaviour:
- Input path: each input passes through a 2-flop synchroniser, then into the `stable` register (see Configuration).
- Edge detect: `prev` holds the value of `stable` from the previous clock. For each bit i, the edge condition is:
  - rising: `stable[i] & ~prev[i]` when `POL[i]`=0;
  - falling: `~stable[i] & prev[i]` when `POL[i]`=1.
- When the edge condition is true, `EDGE[i]` is set at the next clock.
- EDGE set/clear collision: if a set and a write-1-to-clear of the same bit occur in the same cycle, the set wins.
- Capture is independent of MASK: flags capture even while masked.
- Interrupt: `irq` <= |(EDGE & MASK), registered. It stays high until the CPU clears the contributing flags or masks them.
- Writes take effect on the clock where `write_strobe`=1 and `port_id` decodes to a mapped register.
- Read path: `in_port` is updated every clock from the current `port_id` decode. `read_strobe` has no side effects (no clear-on-read). Unmapped `port_id` returns 0x00, so bamse can OR several peripherals onto one bus.
- Reset values (all outputs and registers):
  - `pins_out`, `in_port`, `irq`: 0.
  - OUT, EDGE, MASK, POL: 0.
  - Synchroniser flops, `stable`, `prev`, debounce counters: 0.
- Reset mid-operation: all of the above clear on that edge and any debounce in progress is discarded. An input already high at reset release produces one rising event once it propagates to `stable`. Because MASK is 0 after reset, this event does not assert `irq`.

## Timing
- Pin to `stable`:
  - 2 clocks without debounce;
  - 2 + `DEBOUNCE_CYCLES` clocks with debounce, for a clean transition.
- `stable` change to EDGE flag: +1 clock. EDGE flag to `irq`: +1 clock.
- Write to OUT: `pins_out` changes at the strobe clock edge.
- `port_id` to `in_port`: 1 clock. This meets the KCPSM3 INPUT 2-cycle instruction timing.
- W1C to `irq` deassert: 2 clocks, provided no new edge arrives.

## Configuration
- `GPIO_DEBOUNCE_EN` defined:
  - Each input bit has a counter of width clog2(`DEBOUNCE_CYCLES`+1).
  - The counter increments while the synchronised bit differs from `stable`, and resets to 0 whenever they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`, `stable` takes the synchronised value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` clocks never reaches `stable`.
- Not defined: no counters are instantiated; `stable` <= synchronised value every clock; `DEBOUNCE_CYCLES` is ignored.

## Test plan
- Reset with `rst` held 3 clocks, `pins_in`=0xFF → after release `pins_out`=0x00, `irq`=0, `in_port`=0x00. Reading offset 2 once inputs settle → 0xFF (rising events), `irq` stays 0.
- Debounce (`GPIO_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=4):
  - a 3-clock pulse on `pins_in[0]` → IN stays 0x00 and EDGE stays 0x00;
  - a 10-clock pulse → IN[0]=1 exactly 6 clocks after the pin rises.
- Interrupt (MASK=0x01, POL=0x00): rising edge on `pins_in[0]` → EDGE=0x01 and `irq`=1. Write 0x01 to offset 2 → `irq`=0 two clocks later.
- Falling polarity (POL=0x02): a falling edge on bit 1 sets EDGE bit 1 (EDGE=0x02); a rising edge on bit 1 leaves EDGE bit 1 at 0.
- Collision: assert an edge on bit 2 in the same cycle as W1C 0x04 → EDGE[2] remains 1.
- Bus decode (`BASE_ADDR`=0x10, `OUT_WIDTH`=4):
  - write 0xA5 to 0x11 → `pins_out`=0x5 and a read of 0x11 returns 0x05;
  - a read of 0x17 returns 0x00;
  - a write to 0x21 leaves OUT unchanged.

Source files
------------

// File: rtl/bamse_gpio.sv
// bamse_gpio: PicoBlaze port-mapped GPIO with synchronised inputs, edge capture and maskable irq.
// Define GPIO_DEBOUNCE_EN to add a per-bit debounce counter in front of the stable register.
module bamse_gpio #(
   parameter int          IN_WIDTH        = 8,
   parameter int          OUT_WIDTH       = 8,
   parameter logic [7:0]  BASE_ADDR       = 8'h00,
   parameter int          DEBOUNCE_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           port_id,
   input  logic                 write_strobe,
   input  logic                 read_strobe,
   input  logic [7:0]           out_port,
   output logic [7:0]           in_port,
   input  logic [IN_WIDTH-1:0]  pins_in,
   output logic [OUT_WIDTH-1:0] pins_out,
   output logic                 irq
);

   localparam logic [2:0] OFS_IN   = 3'd0;
   localparam logic [2:0] OFS_OUT  = 3'd1;
   localparam logic [2:0] OFS_EDGE = 3'd2;
   localparam logic [2:0] OFS_MASK = 3'd3;
   localparam logic [2:0] OFS_POL  = 3'd4;

   logic [IN_WIDTH-1:0]  sync1_q, sync2_q;
   logic [IN_WIDTH-1:0]  stable_q, stable_d;
   logic [IN_WIDTH-1:0]  prev_q;
   logic [IN_WIDTH-1:0]  edge_q, edge_d;
   logic [IN_WIDTH-1:0]  mask_q, mask_d;
   logic [IN_WIDTH-1:0]  pol_q, pol_d;
   logic [OUT_WIDTH-1:0] out_q, out_d;
   logic [7:0]           in_port_q, in_port_d;
   logic                 irq_q, irq_d;

   logic                 hit;
   logic [2:0]           ofs;
   logic [IN_WIDTH-1:0]  edge_set;
   logic [IN_WIDTH-1:0]  edge_clr;
   logic                 unused_bits;

   // read_strobe carries no side effects and upper data bits are unused for narrow widths.
   assign unused_bits = ^{read_strobe, out_port};

   assign hit = (port_id[7:3] == BASE_ADDR[7:3]);
   assign ofs = port_id[2:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= pins_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] cnt_q [IN_WIDTH];
   logic [CNT_W-1:0] cnt_d [IN_WIDTH];

   // A bit is accepted only after it has differed from stable for DEBOUNCE_CYCLES clocks in a row.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < IN_WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '{default: '0};
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   localparam int db_cycles_unused = DEBOUNCE_CYCLES;

   assign stable_d = sync2_q;
`endif

   always_comb begin
      edge_set = (stable_q & ~prev_q & ~pol_q) | (~stable_q & prev_q & pol_q);
      edge_clr = '0;
      out_d    = out_q;
      mask_d   = mask_q;
      pol_d    = pol_q;
      if (write_strobe && hit) begin
         case (ofs)
            OFS_OUT:  out_d    = out_port[OUT_WIDTH-1:0];
            OFS_EDGE: edge_clr = out_port[IN_WIDTH-1:0];
            OFS_MASK: mask_d   = out_port[IN_WIDTH-1:0];
            OFS_POL:  pol_d    = out_port[IN_WIDTH-1:0];
            default:  ;
         endcase
      end
      // A new edge in the same cycle as its clear must not be lost.
      edge_d = (edge_q & ~edge_clr) | edge_set;
      irq_d  = |(edge_q & mask_q);
   end

   always_comb begin
      in_port_d = '0;
      if (hit) begin
         case (ofs)
            OFS_IN:   in_port_d[IN_WIDTH-1:0]  = stable_q;
            OFS_OUT:  in_port_d[OUT_WIDTH-1:0] = out_q;
            OFS_EDGE: in_port_d[IN_WIDTH-1:0]  = edge_q;
            OFS_MASK: in_port_d[IN_WIDTH-1:0]  = mask_q;
            OFS_POL:  in_port_d[IN_WIDTH-1:0]  = pol_q;
            default:  in_port_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stable_q  <= '0;
         prev_q    <= '0;
         edge_q    <= '0;
         mask_q    <= '0;
         pol_q     <= '0;
         out_q     <= '0;
         in_port_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         stable_q  <= stable_d;
         prev_q    <= stable_q;
         edge_q    <= edge_d;
         mask_q    <= mask_d;
         pol_q     <= pol_d;
         out_q     <= out_d;
         in_port_q <= in_port_d;
         irq_q     <= irq_d;
      end
   end

   assign in_port  = in_port_q;
   assign pins_out = out_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_bamse_gpio.sv
// Directed bench for bamse_gpio at BASE_ADDR=0x10, OUT_WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_bamse_gpio;

   localparam logic [7:0] A_IN   = 8'h10;
   localparam logic [7:0] A_OUT  = 8'h11;
   localparam logic [7:0] A_EDGE = 8'h12;
   localparam logic [7:0] A_MASK = 8'h13;
   localparam logic [7:0] A_POL  = 8'h14;
   localparam int         SETTLE = 16;
   // Clock edges from driving a pin to stable changing (edge 1 samples the pin,
   // stable follows 2 or 2+DEBOUNCE_CYCLES edges later); in_port shows it one edge after that.
`ifdef GPIO_DEBOUNCE_EN
   localparam int STB_LAT = 7;
`else
   localparam int STB_LAT = 3;
`endif
   localparam int PIN2IN = STB_LAT + 1;

   logic       clk;
   logic       rst;
   logic [7:0] port_id;
   logic       write_strobe;
   logic       read_strobe;
   logic [7:0] out_port;
   logic [7:0] in_port;
   logic [7:0] pins_in;
   logic [3:0] pins_out;
   logic       irq;

   int n_tests;
   int n_fail;

   bamse_gpio #(
      .IN_WIDTH        (8),
      .OUT_WIDTH       (4),
      .BASE_ADDR       (8'h10),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .port_id      (port_id),
      .write_strobe (write_strobe),
      .read_strobe  (read_strobe),
      .out_port     (out_port),
      .in_port      (in_port),
      .pins_in      (pins_in),
      .pins_out     (pins_out),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      port_id      = a;
      out_port     = d;
      write_strobe = 1'b1;
      tick();
      write_strobe = 1'b0;
      port_id      = 8'h00;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      port_id     = a;
      read_strobe = 1'b1;
      tick();
      d           = in_port;
      read_strobe = 1'b0;
      port_id     = 8'h00;
   endtask

   task automatic settle();
      repeat (SETTLE) tick();
   endtask

   task automatic test_reset();
      logic [7:0] d;
      pins_in = 8'hFF;
      rst     = 1'b1;
      repeat (3) tick();
      n_tests++; if (pins_out !== 4'h0) begin n_fail++; $display("FAIL rst_pins_out: got %h want 0", pins_out); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq); end
      n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL rst_in_port: got %h want 00", in_port); end
      rst = 1'b0;
      tick();
      n_tests++; if (pins_out !== 4'h0) begin n_fail++; $display("FAIL rel_pins_out: got %h want 0", pins_out); end
      n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL rel_in_port: got %h want 00", in_port); end
      settle();
      rd(A_EDGE, d);
      n_tests++; if (d !== 8'hFF) begin n_fail++; $display("FAIL rst_edge_events: got %h want ff", d); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq_masked: got %b want 0", irq); end
      rd(A_IN, d);
      n_tests++; if (d !== 8'hFF) begin n_fail++; $display("FAIL rst_in_reg: got %h want ff", d); end
      pins_in = 8'h00;
      settle();
      wr(A_EDGE, 8'hFF);
      rd(A_EDGE, d);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_edge_cleared: got %h want 00", d); end
   endtask

   task automatic test_input_latency();
      port_id    = A_IN;
      pins_in[0] = 1'b1;
      repeat (PIN2IN - 1) tick();
      n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL lat_early: got %h want 00", in_port); end
      tick();
      n_tests++; if (in_port !== 8'h01) begin n_fail++; $display("FAIL lat_exact: got %h want 01", in_port); end
      repeat (10 - PIN2IN) tick();
      pins_in[0] = 1'b0;
      settle();
      n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL lat_fall: got %h want 00", in_port); end
      wr(A_EDGE, 8'hFF);
   endtask

`ifdef GPIO_DEBOUNCE_EN
   task automatic test_debounce_glitch();
      logic       seen;
      logic [7:0] d;
      seen       = 1'b0;
      port_id    = A_IN;
      pins_in[0] = 1'b1;
      repeat (3) tick();
      pins_in[0] = 1'b0;
      repeat (20) begin
         tick();
         if (in_port !== 8'h00) seen = 1'b1;
      end
      n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL glitch_in: got seen=%b want 0", seen); end
      rd(A_EDGE, d);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL glitch_edge: got %h want 00", d); end
   endtask
`endif

   task automatic test_irq();
      logic [7:0] d;
      wr(A_MASK, 8'h01);
      wr(A_POL, 8'h00);
      pins_in[0] = 1'b1;
      settle();
      rd(A_EDGE, d);
      n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL irq_edge: got %h want 01", d); end
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq); end
      rd(A_EDGE, d);
      n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL irq_no_clr_on_read: got %h want 01", d); end
      wr(A_EDGE, 8'h01);
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_w1c_1clk: got %b want 1", irq); end
      tick();
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_w1c_2clk: got %b want 0", irq); end
      pins_in[3] = 1'b1;
      settle();
      rd(A_EDGE, d);
      n_tests++; if (d !== 8'h08) begin n_fail++; $display("FAIL irq_masked_capture: got %h want 08", d); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked_quiet: got %b want 0", irq); end
      pins_in = 8'h00;
      settle();
      wr(A_EDGE, 8'hFF);
      wr(A_MASK, 8'h00);
   endtask

   task automatic test_polarity();
      logic [7:0] d;
      wr(A_POL, 8'h02);
      pins_in[1] = 1'b1;
      settle();
      rd(A_EDGE, d);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL pol_rise_ignored: got %h want 00", d); end
      pins_in[1] = 1'b0;
      settle();
      rd(A_EDGE, d);
      n_tests++; if (d !== 8'h02) begin n_fail++; $display("FAIL pol_fall_captured: got %h want 02", d); end
      rd(A_POL, d);
      n_tests++; if (d !== 8'h02) begin n_fail++; $display("FAIL pol_readback: got %h want 02", d); end
      wr(A_EDGE, 8'h02);
      wr(A_POL, 8'h00);
   endtask

   task automatic test_collision();
      logic [7:0] d;
      rd(A_EDGE, d);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL coll_pre: got %h want 00", d); end
      pins_in[2] = 1'b1;
      repeat (STB_LAT) tick();
      // This write is sampled on the same edge that sets EDGE[2].
      wr(A_EDGE, 8'h04);
      rd(A_EDGE, d);
      n_tests++; if (d !== 8'h04) begin n_fail++; $display("FAIL coll_set_wins: got %h want 04", d); end
      wr(A_EDGE, 8'h04);
      rd(A_EDGE, d);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL coll_later_clear: got %h want 00", d); end
      pins_in = 8'h00;
      settle();
   endtask

   task automatic test_bus();
      logic [7:0] d;
      wr(A_OUT, 8'hA5);
      n_tests++; if (pins_out !== 4'h5) begin n_fail++; $display("FAIL bus_pins_out: got %h want 5", pins_out); end
      rd(A_OUT, d);
      n_tests++; if (d !== 8'h05) begin n_fail++; $display("FAIL bus_out_read: got %h want 05", d); end
      rd(8'h17, d);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL bus_ofs7: got %h want 00", d); end
      wr(8'h21, 8'h3C);
      n_tests++; if (pins_out !== 4'h5) begin n_fail++; $display("FAIL bus_foreign_write: got %h want 5", pins_out); end
      wr(8'h15, 8'hFF);
      wr(A_MASK, 8'h81);
      rd(A_MASK, d);
      n_tests++; if (d !== 8'h81) begin n_fail++; $display("FAIL bus_mask_read: got %h want 81", d); end
      rd(8'h15, d);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL bus_ofs5: got %h want 00", d); end
      rd(8'h01, d);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL bus_unmapped: got %h want 00", d); end
      wr(A_MASK, 8'h00);
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      wr(A_MASK, 8'h01);
      pins_in[0] = 1'b1;
      settle();
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_irq_before: got %b want 1", irq); end
      port_id = A_OUT;
      rst     = 1'b1;
      tick();
      n_tests++; if (pins_out !== 4'h0) begin n_fail++; $display("FAIL mid_pins_out: got %h want 0", pins_out); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq: got %b want 0", irq); end
      n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL mid_in_port: got %h want 00", in_port); end
      rst     = 1'b0;
      port_id = 8'h00;
      settle();
      rd(A_EDGE, d);
      n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL mid_rerise_edge: got %h want 01", d); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq_after: got %b want 0", irq); end
      rd(A_MASK, d);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL mid_mask: got %h want 00", d); end
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      rst          = 1'b1;
      port_id      = 8'h00;
      write_strobe = 1'b0;
      read_strobe  = 1'b0;
      out_port     = 8'h00;
      pins_in      = 8'h00;
      test_reset();
      test_input_latency();
`ifdef GPIO_DEBOUNCE_EN
      test_debounce_glitch();
`endif
      test_irq();
      test_polarity();
      test_collision();
      test_bus();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
